// File: rtl/mem_access_ctrl_if.sv
// Request/response and Datmem bus for the load/store controller.
interface mem_access_ctrl_if #(parameter int AWIDTH = 32);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [AWIDTH-1:0] ReqAddr;
  logic [AWIDTH-1:0] ReqWData;
  logic              RspValid;
  logic [AWIDTH-1:0] RspData;
  logic              RspFault;
  logic [AWIDTH-1:0] MemAddr;
  logic              MemWE;
  logic [AWIDTH-1:0] MemWData;
  logic [AWIDTH-1:0] MemRData;

  // master: execute stage plus Datmem; slave: the controller
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData,
    input  ReqReady, RspValid, RspData, RspFault, MemAddr, MemWE, MemWData
  );
  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemRData,
    output ReqReady, RspValid, RspData, RspFault, MemAddr, MemWE, MemWData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a word-indexed data memory.
// Sub-word stores go through read-modify-write; every output is a flop.
module mem_access_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP, FAULT_RSP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  localparam logic [AWIDTH-3:0] ALEN = (AWIDTH-2)'(ALENGTH);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [AWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              signed_q, signed_d;
  logic              fault;
  logic [AWIDTH-1:0] merged;

  function automatic logic [AWIDTH-1:0] load_ext(input logic [AWIDTH-1:0] w,
      input logic [1:0] off, input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: return {{(AWIDTH-8){sg & b[7]}}, b};
      SZ_HALF: return {{(AWIDTH-16){sg & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    fault = (bus.ReqAddr[AWIDTH-1:2] >= ALEN) || (bus.ReqSize == 2'b11) ||
            (bus.ReqSize == SZ_HALF && bus.ReqAddr[0]) ||
            (bus.ReqSize == SZ_WORD && bus.ReqAddr[1:0] != 2'b00);
    // new lane spliced into the word read during RMW_RD
    merged = bus.MemRData;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                   merged[{addr_q[1],  4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_data_d  = '0;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    write_d     = write_q;
    signed_d    = signed_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.ReqValid) begin
          addr_d   = bus.ReqAddr;
          wdata_d  = bus.ReqWData;
          size_d   = bus.ReqSize;
          write_d  = bus.ReqWrite;
          signed_d = bus.ReqSigned;
          ready_d  = 1'b0;
          if (fault) begin
            state_d     = FAULT_RSP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else begin
            mem_addr_d = {2'b00, bus.ReqAddr[AWIDTH-1:2]};
            if (bus.ReqWrite && bus.ReqSize != SZ_WORD) begin
              state_d = RMW_RD;
            end else begin
              state_d     = ACCESS;
              mem_we_d    = bus.ReqWrite;
              mem_wdata_d = bus.ReqWrite ? bus.ReqWData : '0;
            end
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = write_q ? '0 : load_ext(bus.MemRData, addr_q[1:0], size_q, signed_q);
      end
      RMW_RD: begin
        state_d     = RMW_WR;
        mem_addr_d  = {2'b00, addr_q[AWIDTH-1:2]};
        mem_we_d    = 1'b1;
        mem_wdata_d = merged;
      end
      RMW_WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      write_q     <= write_d;
      signed_q    <= signed_d;
    end
  end

  assign bus.ReqReady = ready_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspFault = rsp_fault_q;
  assign bus.RspData  = rsp_data_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWE    = mem_we_q;
  assign bus.MemWData = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Random + directed load/store traffic against an array-based reference of Datmem.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_access_ctrl_if #(.AWIDTH(32)) bus();
  mem_access_ctrl #(.AWIDTH(32), .ALENGTH(128)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [31:0] mem [128] = '{default: 32'h0};
  logic [31:0] ref_mem [128];

  assign bus.MemRData = (bus.MemAddr < 32'd128) ? mem[bus.MemAddr[6:0]] : 32'h0;
  always @(posedge clk) if (bus.MemWE && bus.MemAddr < 32'd128) mem[bus.MemAddr[6:0]] <= bus.MemWData;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: fault rules, lane extraction and lane merge from plain shifts and masks.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx, word, v, exp_data, we_addr, we_data, got_data, exp_wdata;
    int sh, exp_lat, lat, wes;
    logic fault, got_fault;
    idx   = a >> 2;
    fault = (idx >= 128) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0);
    exp_data = 0; exp_wdata = 0;
    word = fault ? 32'h0 : ref_mem[idx[6:0]];
    if (fault) exp_lat = 1;
    else if (w && sz != 2'd2) exp_lat = 3;
    else exp_lat = 2;
    if (!fault && !w) begin
      if (sz == 2'd0) begin
        sh = 8 * int'(a[1:0]); v = (word >> sh) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        sh = 16 * int'(a[1]); v = (word >> sh) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else v = word;
      exp_data = v;
    end
    if (!fault && w) begin
      if (sz == 2'd2) exp_wdata = d;
      else if (sz == 2'd0) begin
        sh = 8 * int'(a[1:0]);
        exp_wdata = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else begin
        sh = 16 * int'(a[1]);
        exp_wdata = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      ref_mem[idx[6:0]] = exp_wdata;
    end

    @(negedge clk);
    chk("ready_before", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqSize = sz; bus.ReqSigned = sg;
    bus.ReqAddr = a; bus.ReqWData = d;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    bus.ReqAddr = $urandom; bus.ReqWData = $urandom;
    lat = 0; wes = 0; we_addr = 0; we_data = 0; got_data = 0; got_fault = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("ready_busy", 32'(bus.ReqReady), 32'd0);
      if (bus.MemWE) begin wes++; we_addr = bus.MemAddr; we_data = bus.MemWData; end
      if (bus.RspValid) begin lat = c; got_data = bus.RspData; got_fault = bus.RspFault; end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_fault", 32'(got_fault), 32'(fault));
    chk("rsp_data", got_data, exp_data);
    chk("we_count", 32'(wes), (w && !fault) ? 32'd1 : 32'd0);
    if (w && !fault) begin
      chk("we_addr", we_addr, idx);
      chk("we_data", we_data, exp_wdata);
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(bus.RspValid), 32'd0);
    chk("idle_mem_addr", bus.MemAddr, 32'd0);
    if (!fault) chk("mem_word", mem[idx[6:0]], ref_mem[idx[6:0]]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ReqReady), 32'd1);
    chk("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    chk("rst_mem_we", 32'(bus.MemWE), 32'd0);
    chk("rst_mem_addr", bus.MemAddr, 32'd0);
    chk("rst_rsp_data", bus.RspData, 32'd0);
    rst = 1'b0;

    // directed scenarios
    do_req(1, 2'd2, 0, 32'h000000DC, 32'h00006000);
    do_req(1, 2'd2, 0, 32'h00000000, 32'h80018100);
    do_req(0, 2'd0, 1, 32'h00000001, 32'h0);
    do_req(0, 2'd0, 0, 32'h00000001, 32'h0);
    do_req(0, 2'd1, 1, 32'h00000002, 32'h0);
    do_req(1, 2'd0, 0, 32'h000000DE, 32'h000000AB);
    do_req(0, 2'd2, 0, 32'h000000DC, 32'h0);
    chk("rmw_result", ref_mem[8'h37], 32'h00AB6000);
    do_req(1, 2'd2, 0, 32'hFFFFFFFF, 32'h00006001);
    do_req(0, 2'd2, 0, 32'h00000200, 32'h0);
    do_req(0, 2'd2, 0, 32'h000001FC, 32'h0);
    do_req(1, 2'd1, 0, 32'h00000003, 32'h1234);
    do_req(1, 2'd3, 0, 32'h00000010, 32'h1234);

    // reset while a byte store sits in its read phase
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'd0; bus.ReqSigned = 1'b0;
    bus.ReqAddr = 32'h000000DD; bus.ReqWData = 32'h000000EE;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    we_seen = int'(bus.MemWE);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    we_seen += int'(bus.MemWE);
    chk("abort_ready", 32'(bus.ReqReady), 32'd1);
    chk("abort_rsp_valid", 32'(bus.RspValid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      we_seen += int'(bus.MemWE);
      if (bus.RspValid) we_seen += 100;
    end
    chk("abort_no_write", 32'(we_seen), 32'd0);
    chk("abort_word", mem[8'h37], ref_mem[8'h37]);

    // random traffic, mostly in range with a few wild addresses
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h21F));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom);
    end
    for (int i = 0; i < 128; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
